// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, funct codes and ALU class enum
//
// Purpose: constants shared by the ID/EX feed stage and the single-cycle
// datapath so both agree on the 4-bit ALU operation encoding.
// Ports: none (package).
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_ILL = 4'd15;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'b00,
        CLS_SUB   = 2'b01,
        CLS_RTYPE = 2'b10,
        CLS_SLT   = 2'b11
    } alu_class_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational main-control class / funct to ALU op decode
//
// Purpose: translate the 2-bit ALU class from main control plus the R-type
// funct field into the 4-bit ALU operation code.
// Ports:
//   alu_class in  2  00 add, 01 sub, 10 R-type, 11 slt
//   funct     in  6  R-type function field
//   alu_op    out 4  ALU operation code
//   illegal   out 1  unsupported funct under the R-type class
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (alu_class_e'(alu_class))
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_SLT: alu_op = ALU_SLT;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_op = ALU_ADD;
                    FUNCT_SUB: alu_op = ALU_SUB;
                    FUNCT_AND: alu_op = ALU_AND;
                    FUNCT_OR:  alu_op = ALU_OR;
                    FUNCT_NOR: alu_op = ALU_NOR;
                    FUNCT_SLT: alu_op = ALU_SLT;
                    default: begin
                        // The ALU drives 0 for this code, so the instruction is harmless downstream.
                        alu_op  = ALU_ILL;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_alu_feed.sv
// rtl/id_ex_alu_feed.sv - ID/EX pipeline register feeding the ALU from flops
//
// Purpose: capture decoded operands/control over valid/ready, decode the ALU
// op, select operand 2 and hold everything stable for the ALU.
// Optional feature macro: ID_EX_FORWARD_EN (operand forwarding at capture).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          decode-side handshake
//   rs_data, rt_data, imm      register read data and sign-extended immediate
//   alu_src                    1: operand 2 = imm, 0: operand 2 = rt_data
//   alu_class, funct           main-control ALU class and R-type funct
//   rs_addr, rt_addr, dest_addr  source and destination register numbers
//   flush                      kill the held entry and any capture this cycle
//   out_valid/out_ready        ALU-side handshake
//   alu_op, input_1, input_2   registered ALU op and operands
//   dest_out, illegal          registered destination and illegal-funct flag
//   exmem_*/memwb_*            forwarding sources (ID_EX_FORWARD_EN only)
module id_ex_alu_feed
    import alu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [DW-1:0] imm,
    input  logic          alu_src,
    input  logic [1:0]    alu_class,
    input  logic [5:0]    funct,
    input  logic [RW-1:0] rs_addr,
    input  logic [RW-1:0] rt_addr,
    input  logic [RW-1:0] dest_addr,
    input  logic          flush,
`ifdef ID_EX_FORWARD_EN
    input  logic          exmem_wen,
    input  logic [RW-1:0] exmem_addr,
    input  logic [DW-1:0] exmem_data,
    input  logic          memwb_wen,
    input  logic [RW-1:0] memwb_addr,
    input  logic [DW-1:0] memwb_data,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] input_1,
    output logic [DW-1:0] input_2,
    output logic [RW-1:0] dest_out,
    output logic          illegal
);

    logic          out_valid_q, out_valid_d;
    logic [3:0]    alu_op_q,    alu_op_d;
    logic [DW-1:0] input_1_q,   input_1_d;
    logic [DW-1:0] input_2_q,   input_2_d;
    logic [RW-1:0] dest_q,      dest_d;
    logic          illegal_q,   illegal_d;

    logic [3:0]    dec_op;
    logic          dec_illegal;
    logic [DW-1:0] rs_val, rt_val;
    logic          capture;

    alu_ctrl_decode u_decode (
        .alu_class (alu_class),
        .funct     (funct),
        .alu_op    (dec_op),
        .illegal   (dec_illegal)
    );

`ifdef ID_EX_FORWARD_EN
    // Register 0 is hard-wired, so writes to it never forward. EX/MEM is the
    // younger result and wins over MEM/WB.
    always_comb begin
        rs_val = rs_data;
        if (exmem_wen && exmem_addr != '0 && exmem_addr == rs_addr)
            rs_val = exmem_data;
        else if (memwb_wen && memwb_addr != '0 && memwb_addr == rs_addr)
            rs_val = memwb_data;

        rt_val = rt_data;
        if (exmem_wen && exmem_addr != '0 && exmem_addr == rt_addr)
            rt_val = exmem_data;
        else if (memwb_wen && memwb_addr != '0 && memwb_addr == rt_addr)
            rt_val = memwb_data;
    end
`else
    logic unused_src_addr;
    assign unused_src_addr = ^{rs_addr, rt_addr};
    assign rs_val = rs_data;
    assign rt_val = rt_data;
`endif

    // No skid buffer: a full register only accepts when it drains this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_op_d    = alu_op_q;
        input_1_d   = input_1_q;
        input_2_d   = input_2_q;
        dest_d      = dest_q;
        illegal_d   = illegal_q;
        if (flush) begin
            // Data registers deliberately keep their contents; only validity drops.
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            alu_op_d    = dec_op;
            input_1_d   = rs_val;
            input_2_d   = alu_src ? imm : rt_val;
            dest_d      = dest_addr;
            illegal_d   = dec_illegal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            input_1_q   <= '0;
            input_2_q   <= '0;
            dest_q      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            input_1_q   <= input_1_d;
            input_2_q   <= input_2_d;
            dest_q      <= dest_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_op    = alu_op_q;
    assign input_1   = input_1_q;
    assign input_2   = input_2_q;
    assign dest_out  = dest_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// tb/tb_id_ex_alu_feed.sv - self-checking bench for id_ex_alu_feed
module tb_id_ex_alu_feed;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic          alu_src;
    logic [1:0]    alu_class;
    logic [5:0]    funct;
    logic [RW-1:0] rs_addr, rt_addr, dest_addr;
    logic          flush;
    logic          exmem_wen, memwb_wen;
    logic [RW-1:0] exmem_addr, memwb_addr;
    logic [DW-1:0] exmem_data, memwb_data;
    logic          out_valid, out_ready;
    logic [3:0]    alu_op;
    logic [DW-1:0] input_1, input_2;
    logic [RW-1:0] dest_out;
    logic          illegal;

    always #5 clk = ~clk;

    id_ex_alu_feed #(.DW(DW), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm        (imm),
        .alu_src    (alu_src),
        .alu_class  (alu_class),
        .funct      (funct),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .dest_addr  (dest_addr),
        .flush      (flush),
`ifdef ID_EX_FORWARD_EN
        .exmem_wen  (exmem_wen),
        .exmem_addr (exmem_addr),
        .exmem_data (exmem_data),
        .memwb_wen  (memwb_wen),
        .memwb_addr (memwb_addr),
        .memwb_data (memwb_data),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_op     (alu_op),
        .input_1    (input_1),
        .input_2    (input_2),
        .dest_out   (dest_out),
        .illegal    (illegal)
    );

    int total = 0;
    int bad   = 0;

    // Reference: one held entry described by its architectural contents.
    logic          m_valid;
    logic [3:0]    m_op;
    logic [DW-1:0] m_in1, m_in2;
    logic [RW-1:0] m_dest;
    logic          m_ill;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // {illegal, op} from the opcode table.
    function automatic logic [4:0] ref_decode(input logic [1:0] cls, input logic [5:0] f);
        if (cls == 2'd0) return {1'b0, 4'd2};
        if (cls == 2'd1) return {1'b0, 4'd6};
        if (cls == 2'd3) return {1'b0, 4'd7};
        case (f)
            6'h20:   return {1'b0, 4'd2};
            6'h22:   return {1'b0, 4'd6};
            6'h24:   return {1'b0, 4'd0};
            6'h25:   return {1'b0, 4'd1};
            6'h27:   return {1'b0, 4'd12};
            6'h2A:   return {1'b0, 4'd7};
            default: return {1'b1, 4'd15};
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_src(input logic [RW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] v;
        v = d;
`ifdef ID_EX_FORWARD_EN
        if (exmem_wen && exmem_addr != 0 && exmem_addr == a) v = exmem_data;
        else if (memwb_wen && memwb_addr != 0 && memwb_addr == a) v = memwb_data;
`else
        if (a === 'x) v = 'x;
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_op = '0; m_in1 = '0; m_in2 = '0; m_dest = '0; m_ill = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("alu_op",    32'(alu_op),    32'(m_op));
        chk("input_1",   input_1,        m_in1);
        chk("input_2",   input_2,        m_in2);
        chk("dest_out",  32'(dest_out),  32'(m_dest));
        chk("illegal",   32'(illegal),   32'(m_ill));
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        logic          cap;
        logic [4:0]    dec;
        logic [DW-1:0] s1, s2;
        #1;
        chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
        cap = in_valid && (!m_valid || out_ready) && !flush;
        dec = ref_decode(alu_class, funct);
        s1  = ref_src(rs_addr, rs_data);
        s2  = alu_src ? imm : ref_src(rt_addr, rt_data);
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_ill   = 1'b0;
        end else if (cap) begin
            m_valid = 1'b1;
            m_op    = dec[3:0];
            m_ill   = dec[4];
            m_in1   = s1;
            m_in2   = s2;
            m_dest  = dest_addr;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_instr(input logic [1:0] cls, input logic [5:0] f,
                             input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                             input logic [DW-1:0] im, input logic src, input logic [RW-1:0] dst);
        in_valid = 1'b1; alu_class = cls; funct = f; rs_data = rs; rt_data = rt;
        imm = im; alu_src = src; dest_addr = dst;
    endtask

    initial begin
        logic [5:0] legal_f [6];
        legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        rs_data = '0; rt_data = '0; imm = '0; alu_src = 1'b0; alu_class = '0; funct = '0;
        rs_addr = '0; rt_addr = '0; dest_addr = '0;
        exmem_wen = 1'b0; exmem_addr = '0; exmem_data = '0;
        memwb_wen = 1'b0; memwb_addr = '0; memwb_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // R-type OR
        set_instr(2'b10, 6'h25, 32'hF0, 32'h0F, 32'h0, 1'b0, 5'd3);
        step();
        chk("or_valid", 32'(out_valid), 32'd1);
        chk("or_op",    32'(alu_op),    32'd1);
        chk("or_in1",   input_1,        32'hF0);
        chk("or_in2",   input_2,        32'h0F);

        // class add with immediate
        set_instr(2'b00, 6'h00, 32'h10, 32'h99, 32'hFFFFFFFC, 1'b1, 5'd4);
        step();
        chk("addi_op",  32'(alu_op), 32'd2);
        chk("addi_in2", input_2,     32'hFFFFFFFC);

        // illegal funct, then a legal one clears the flag
        set_instr(2'b10, 6'h03, 32'h1, 32'h2, 32'h0, 1'b0, 5'd5);
        step();
        chk("ill_op",   32'(alu_op),  32'd15);
        chk("ill_flag", 32'(illegal), 32'd1);
        set_instr(2'b10, 6'h22, 32'h11, 32'h22, 32'h0, 1'b0, 5'd6);
        step();
        chk("ill_clear", 32'(illegal), 32'd0);
        chk("sub_op",    32'(alu_op),  32'd6);

        // stall three cycles with a pending instruction
        out_ready = 1'b0;
        set_instr(2'b10, 6'h24, 32'h55, 32'h66, 32'h0, 1'b0, 5'd7);
        repeat (3) begin
            step();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_in1",      input_1,       32'h11);
        end
        out_ready = 1'b1;
        set_instr(2'b11, 6'h00, 32'h77, 32'h88, 32'h0, 1'b0, 5'd8);
        step();
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_in1",   input_1,        32'h77);
        chk("nobubble_op",    32'(alu_op),    32'd7);

        // flush while full with a pending capture
        flush = 1'b1;
        set_instr(2'b00, 6'h00, 32'hAB, 32'hCD, 32'h0, 1'b0, 5'd9);
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_in1",   input_1,        32'h77);
        flush = 1'b0;

`ifdef ID_EX_FORWARD_EN
        set_instr(2'b00, 6'h00, 32'h11, 32'h0, 32'h0, 1'b0, 5'd1);
        rs_addr = 5'd5;
        exmem_wen = 1'b1; exmem_addr = 5'd5; exmem_data = 32'hAA;
        memwb_wen = 1'b1; memwb_addr = 5'd5; memwb_data = 32'hBB;
        step();
        chk("fwd_exmem", input_1, 32'hAA);
        rs_addr = 5'd0; exmem_addr = 5'd0; memwb_addr = 5'd0; rs_data = 32'h33;
        step();
        chk("fwd_r0", input_1, 32'h33);
        exmem_wen = 1'b0; memwb_wen = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            alu_class = 2'($urandom_range(0, 3));
            funct     = ($urandom_range(0, 4) != 0) ? legal_f[$urandom_range(0, 5)]
                                                    : 6'($urandom);
            rs_data   = $urandom; rt_data = $urandom; imm = $urandom;
            alu_src   = 1'($urandom);
            rs_addr   = 5'($urandom_range(0, 3));
            rt_addr   = 5'($urandom_range(0, 3));
            dest_addr = 5'($urandom);
            exmem_wen = 1'($urandom); exmem_addr = 5'($urandom_range(0, 3)); exmem_data = $urandom;
            memwb_wen = 1'($urandom); memwb_addr = 5'($urandom_range(0, 3)); memwb_data = $urandom;
            step();
        end
        flush = 1'b0;

        // asynchronous reset during a stall
        out_ready = 1'b1;
        set_instr(2'b10, 6'h27, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, 5'd12);
        step();
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_op",    32'(alu_op),    32'd0);
        chk("arst_in1",   input_1,        32'd0);
        chk("arst_in2",   input_2,        32'd0);
        chk("arst_dest",  32'(dest_out),  32'd0);
        chk("arst_ready", 32'(in_ready),  32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        set_instr(2'b01, 6'h00, 32'h5, 32'h3, 32'h0, 1'b0, 5'd2);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
